// File: rtl/word_serial_pkg.sv
// Shared types and line levels for the 16-bit word serializer.
// The PARITY state exists only when WORD_SERIALIZER_PARITY_EN is defined.
package word_serial_pkg;

  localparam int   DATA_BITS   = 16;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef WORD_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / serial-out bus of the word serializer; the producer side is master.
interface word_serializer_if;

  logic                                IN_VALID;
  logic [word_serial_pkg::DATA_BITS-1:0] IN_DATA;
  logic                                IN_READY;
  logic                                TX;
  logic                                BUSY;
  logic                                DONE;

  modport master (
    output IN_VALID, IN_DATA,
    input  IN_READY, TX, BUSY, DONE
  );

  modport slave (
    input  IN_VALID, IN_DATA,
    output IN_READY, TX, BUSY, DONE
  );

endinterface

// File: rtl/bit_timer.sv
// Bit-period counter: ticks on the last cycle of every CLKS_PER_BIT-cycle bit,
// held at zero while clear is asserted.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  assign tick = (count_q == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/word_serializer.sv
// 16-bit word to serial line: start bit, data LSB first, optional even parity
// (WORD_SERIALIZER_PARITY_EN), stop bit; each bit lasts CLKS_PER_BIT cycles.
module word_serializer
  import word_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  word_serializer_if.slave bus
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [3:0]             bit_idx_q;
  logic                   tx_q;
  logic                   done_q;
  logic                   tick;
  logic                   idle;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic                   parity_q;
`endif

  assign idle         = (state_q == IDLE);
  assign bus.IN_READY = idle;
  assign bus.BUSY     = ~idle;
  assign bus.TX       = tx_q;
  assign bus.DONE     = done_q;

  // The timer is held in IDLE so START always begins a fresh bit period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clear(idle),
    .tick (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      done_q    <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.IN_VALID) begin
            shift_q   <= bus.IN_DATA;
            bit_idx_q <= '0;
            tx_q      <= START_LEVEL;
            state_q   <= START;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q  <= ^bus.IN_DATA;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == LAST_BIT) begin
`ifdef WORD_SERIALIZER_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= STOP_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_q    <= STOP_LEVEL;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
